// File: rtl/reg_wb_queue.sv
// reg_wb_queue
//   In-order write-back queue in front of the register file write port.
//   Results arrive from the ALU path and the load path over valid/ready
//   handshakes. They are buffered in a small circular FIFO and drained one
//   write per cycle unless wb_hold is high. Writes to x0 are accepted but
//   dropped. A bypass lookup returns the youngest pending value for a register.
//
// Ports
//   clk, rst              : clock; asynchronous active-high reset
//   alu_valid/ready/rd/data : ALU result handshake
//   mem_valid/ready/rd/data : load result handshake (higher priority)
//   wb_hold               : register file port busy, no dequeue
//   wr_addr/wr_data       : head entry (0 when empty)
//   write_back_en         : register file write strobe (pop this cycle)
//   byp_addr              : bypass lookup register index
//   byp_hit/byp_data      : youngest pending match (0 on miss or x0)
//   q_count               : occupied entries
module reg_wb_queue #(
    parameter int reg_addr_width = 5,
    parameter int reg_data_width = 32,
    parameter int q_depth        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [reg_addr_width-1:0]     alu_rd,
    input  logic [reg_data_width-1:0]     alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [reg_addr_width-1:0]     mem_rd,
    input  logic [reg_data_width-1:0]     mem_data,
    input  logic                          wb_hold,
    output logic [reg_addr_width-1:0]     wr_addr,
    output logic [reg_data_width-1:0]     wr_data,
    output logic                          write_back_en,
    input  logic [reg_addr_width-1:0]     byp_addr,
    output logic                          byp_hit,
    output logic [reg_data_width-1:0]     byp_data,
    output logic [$clog2(q_depth):0]      q_count
);

    localparam int PW = $clog2(q_depth);
    localparam int CW = PW + 1;

    logic [reg_addr_width-1:0] rd_mem   [q_depth];
    logic [reg_data_width-1:0] data_mem [q_depth];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic                      full;
    logic                      empty;
    logic                      mem_acc;
    logic                      alu_acc;
    logic                      push;
    logic                      pop;
    logic [reg_addr_width-1:0] sel_rd;
    logic [reg_data_width-1:0] sel_data;
    logic [PW-1:0]             byp_idx;

    assign full  = (count == CW'(q_depth));
    assign empty = (count == '0);

    // Readies look only at full: a pop in the same cycle does not reopen them.
    assign mem_ready = !full && !rst;
    assign alu_ready = !full && !mem_valid && !rst;

    assign mem_acc = mem_valid && mem_ready;
    assign alu_acc = alu_valid && alu_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (mem_acc) begin
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end else if (alu_acc) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    // x0 results complete their handshake but never occupy an entry.
    assign push = (mem_acc || alu_acc) && (sel_rd != '0);
    assign pop  = !empty && !wb_hold;

    assign write_back_en = pop;
    assign wr_addr       = empty ? '0 : rd_mem[rd_ptr];
    assign wr_data       = empty ? '0 : data_mem[rd_ptr];
    assign q_count       = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset: validity is carried by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= sel_rd;
            data_mem[wr_ptr] <= sel_data;
        end
    end

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        for (int unsigned k = 0; k < int'(q_depth); k++) begin
            byp_idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (byp_addr != '0) && (rd_mem[byp_idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = data_mem[byp_idx];
            end
        end
    end

endmodule
